fb_line_prefetch: RTL and testbench

- Sits between the SDRAM controller read port and the video timing/pixel output stage.
- Streams the 1280x720 16-bit framebuffer out of SDRAM as 256-word burst reads, buffers the words in a FIFO, and hands them to the pixel stage one word per pop.
- Framebuffer layout is fixed: word address = LINE_STRIDE*y + x.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_sync_fifo.sv | 70 +++++++
 rtl/fb_line_prefetch.sv | 178 +++++++++++++++++
 tb/tb_fb_line_prefetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer line prefetcher.
//   - Default geometry of the 1280x720 16-bit framebuffer and burst size.
//   - Fetch FSM state encoding.
//   - Burst start address composition (shift/add only).
package fb_pkg;

  localparam int DEF_H_PIXELS    = 1280;
  localparam int DEF_V_LINES     = 720;
  localparam int DEF_LINE_STRIDE = 4096;
  localparam int DEF_BURST_LEN   = 256;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN,
    DONE
  } fb_state_e;

  // Word address of a burst: line*stride + chunk*burst. Stride and burst
  // length are powers of two, so both products reduce to shifts.
  function automatic logic [31:0] compose_addr(input logic [9:0]  line,
                                               input logic [7:0]  chunk,
                                               input int unsigned stride_sh,
                                               input int unsigned burst_sh);
    return ({22'd0, line} << stride_sh) + ({24'd0, chunk} << burst_sh);
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of all contents (wins over push/pop)
//   push, wdata  : write one word (honoured when full only if popping too)
//   pop          : consume head word (ignored when empty)
//   rdata        : head word, combinational from storage; 0 when empty
//   empty        : no words stored
//   free         : number of unused entries
module fb_sync_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];
  assign free    = (PTR_W+1)'(DEPTH) - count;

  // NOTE: the storage array carries no reset; only pointers and count define
  // validity, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_line_prefetch.sv
// Framebuffer line prefetcher: streams the framebuffer out of SDRAM as
// fixed-length burst reads, buffers the words and hands them to the pixel
// stage one word per pop.
//   clk, reset_n      : clock, asynchronous active-low reset
//   frame_start       : vsync pulse, restarts fetching at line 0
//   rd_req, rd_addr   : burst read request and start word address
//   rd_ack            : controller accepted the request
//   rd_valid, rd_data : read data beats
//   pix_pop           : pixel stage consumes the head word
//   pix_data          : head word (0 when empty), pix_avail: FIFO not empty
//   underflow         : sticky pop-while-empty flag, cleared by frame_start
//   frame_fetched     : pulse after the last word of the frame is written
//   line_count        : line currently being fetched
module fb_line_prefetch
  import fb_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES,
  parameter int LINE_STRIDE = DEF_LINE_STRIDE,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int ADDR_W      = 22,
  parameter int FIFO_DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  input  logic              pix_pop,
  output logic [15:0]       pix_data,
  output logic              pix_avail,
  output logic              underflow,
  output logic              frame_fetched,
  output logic [9:0]        line_count
);

  localparam int          N_CHUNKS  = H_PIXELS / BURST_LEN;
  localparam int          CHUNK_W   = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int          BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int          FREE_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STRIDE_SH = $clog2(LINE_STRIDE);
  localparam int unsigned BURST_SH  = $clog2(BURST_LEN);

  fb_state_e          state, state_d;
  logic [9:0]         line_d;
  logic [CHUNK_W-1:0] chunk, chunk_d;
  logic [BEAT_W-1:0]  beat_cnt, beat_d;
  logic               fetched_d;
  logic               restart;
  logic               fifo_push;
  logic               fifo_flush;
  logic               fifo_empty;
  logic [FREE_W-1:0]  fifo_free;
  logic               space_ok;
  logic               last_beat;
  logic               last_chunk;
  logic               last_line;

  fb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wdata   (rd_data),
    .pop     (pix_pop),
    .rdata   (pix_data),
    .empty   (fifo_empty),
    .free    (fifo_free)
  );

  assign pix_avail  = !fifo_empty;
  assign space_ok   = (fifo_free >= FREE_W'(BURST_LEN));
  assign last_beat  = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign last_chunk = (chunk == CHUNK_W'(N_CHUNKS - 1));
  assign last_line  = (line_count == 10'(V_LINES - 1));
  assign rd_addr    = ADDR_W'(compose_addr(line_count, 8'(chunk), STRIDE_SH, BURST_SH));

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    line_d     = line_count;
    chunk_d    = chunk;
    beat_d     = beat_cnt;
    fetched_d  = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    rd_req     = 1'b0;
    restart    = 1'b0;

    case (state)
      IDLE: if (frame_start) restart = 1'b1;

      // Only request when a whole burst is guaranteed to fit.
      REQ: begin
        rd_req = space_ok;
        if (rd_req && rd_ack) begin
          // An accepted request owes us a full burst, even if we restart.
          beat_d  = '0;
          state_d = frame_start ? DRAIN : DATA;
        end else if (frame_start) begin
          restart = 1'b1;
        end
      end

      DATA: begin
        if (rd_valid) beat_d = beat_cnt + 1'b1;
        if (frame_start) begin
          // The beat coinciding with frame_start is already discarded.
          if (rd_valid && last_beat) restart = 1'b1;
          else                       state_d = DRAIN;
        end else if (rd_valid) begin
          fifo_push = 1'b1;
          if (last_beat) begin
            if (last_chunk) begin
              chunk_d = '0;
              if (last_line) begin
                fetched_d = 1'b1;
                state_d   = DONE;
              end else begin
                line_d  = line_count + 1'b1;
                state_d = REQ;
              end
            end else begin
              chunk_d = chunk + 1'b1;
              state_d = REQ;
            end
          end
        end
      end

      DRAIN: begin
        if (rd_valid) begin
          beat_d = beat_cnt + 1'b1;
          if (last_beat) restart = 1'b1;
        end
      end

      DONE: if (frame_start) restart = 1'b1;

      default: state_d = IDLE;
    endcase

    if (restart) begin
      fifo_flush = 1'b1;
      line_d     = '0;
      chunk_d    = '0;
      beat_d     = '0;
      state_d    = REQ;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      line_count    <= '0;
      chunk         <= '0;
      beat_cnt      <= '0;
      frame_fetched <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      state         <= state_d;
      line_count    <= line_d;
      chunk         <= chunk_d;
      beat_cnt      <= beat_d;
      frame_fetched <= fetched_d;
      if (frame_start)              underflow <= 1'b0;
      else if (pix_pop && fifo_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_line_prefetch.sv
// Directed bench for fb_line_prefetch. Full-size line geometry and FIFO,
// with a 4-line frame so a complete frame stays short.
module tb_fb_line_prefetch;

  localparam int H      = 1280;
  localparam int BL     = 256;
  localparam int STRIDE = 4096;
  localparam int VL     = 4;
  localparam int CHUNKS = H / BL;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        pix_pop;
  logic [15:0] pix_data;
  logic        pix_avail;
  logic        underflow;
  logic        frame_fetched;
  logic [9:0]  line_count;

  int passed  = 0;
  int failed  = 0;
  int total   = 0;
  bit auto_pop = 1'b0;
  int exp_x   = 0;
  int pop_cnt = 0;
  int pop_bad = 0;
  int ff_seen = 0;

  always #5 clk = ~clk;

  fb_line_prefetch #(
    .H_PIXELS    (H),
    .V_LINES     (VL),
    .LINE_STRIDE (STRIDE),
    .BURST_LEN   (BL),
    .ADDR_W      (22),
    .FIFO_DEPTH  (1024)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .pix_pop       (pix_pop),
    .pix_data      (pix_data),
    .pix_avail     (pix_avail),
    .underflow     (underflow),
    .frame_fetched (frame_fetched),
    .line_count    (line_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, want);
    end
  endtask

  // Advance to the next falling edge; optionally act as a pixel stage that
  // pops whenever a word is available and compares it with the x model.
  task automatic tick();
    @(negedge clk);
    if (frame_fetched) ff_seen++;
    if (auto_pop) begin
      pix_pop = pix_avail;
      if (pix_avail) begin
        if (pix_data !== 16'(exp_x)) pop_bad++;
        exp_x = (exp_x + 1) % H;
        pop_cnt++;
      end
    end
  endtask

  // Wait for a request, check its address, acknowledge three cycles later.
  task automatic start_burst(input string tag, input logic [21:0] want_addr);
    int n = 0;
    while (!rd_req && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(rd_req), 32'd1);
    check({tag, "_addr"}, 32'(rd_addr), 32'(want_addr));
    repeat (3) tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic do_burst(input string tag, input logic [21:0] want_addr, input int x0);
    start_burst(tag, want_addr);
    for (int b = 0; b < BL; b++) begin
      rd_valid = 1'b1;
      rd_data  = 16'(x0 + b);
      tick();
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int bad;
    int n;

    reset_n = 1'b0; frame_start = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0;
    rd_data = '0; pix_pop = 1'b0;
    #3;
    check("rst_rd_req",   32'(rd_req),        32'd0);
    check("rst_rd_addr",  32'(rd_addr),       32'd0);
    check("rst_pix_data", 32'(pix_data),      32'd0);
    check("rst_avail",    32'(pix_avail),     32'd0);
    check("rst_underflow",32'(underflow),     32'd0);
    check("rst_fetched",  32'(frame_fetched), 32'd0);
    check("rst_line",     32'(line_count),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    check("idle_no_req", 32'(rd_req), 32'd0);

    // ---- Four bursts fill the FIFO, the fifth waits for 256 pops ----
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("t1_req_after_start", 32'(rd_req), 32'd1);
    for (int c = 0; c < 4; c++) do_burst("t1", 22'(c * BL), c * BL);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (rd_req) seen++;
      tick();
    end
    check("t1_stall", 32'(seen), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("t1_stall_at_255_free", 32'(rd_req), 32'd0);
      if (pix_data !== 16'(i)) bad++;
      pix_pop = 1'b1;
      tick();
    end
    pix_pop = 1'b0;
    check("t1_pop_data", 32'(bad), 32'd0);
    check("t1_fifth_req", 32'(rd_req), 32'd1);
    check("t1_fifth_addr", 32'(rd_addr), 32'h400);

    // ---- Full frame, data = x, continuous pops ----
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("t2_flushed", 32'(pix_avail), 32'd0);
    ff_seen = 0; pop_bad = 0; pop_cnt = 0; exp_x = 0; auto_pop = 1'b1;
    for (int y = 0; y < VL; y++)
      for (int c = 0; c < CHUNKS; c++)
        do_burst("t2", 22'(y * STRIDE + c * BL), c * BL);
    check("t2_fetched_pulse", 32'(frame_fetched), 32'd1);
    check("t2_line_at_end", 32'(line_count), 32'(VL - 1));
    tick();
    check("t2_fetched_low", 32'(frame_fetched), 32'd0);
    n = 0;
    while (pop_cnt < VL * H && n < 3000) begin
      tick();
      n++;
    end
    check("t2_pop_count", 32'(pop_cnt), 32'(VL * H));
    check("t2_pop_data", 32'(pop_bad), 32'd0);
    check("t2_fetched_once", 32'(ff_seen), 32'd1);
    check("t2_done_no_req", 32'(rd_req), 32'd0);
    check("t2_line_final", 32'(line_count), 32'(VL - 1));
    auto_pop = 1'b0; pix_pop = 1'b0;

    // ---- frame_start at beat 100 of a burst ----
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    start_burst("t3", 22'h0);
    for (int b = 0; b < 100; b++) begin
      rd_valid = 1'b1; rd_data = 16'(b); tick();
    end
    rd_data = 16'd100; frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int b = 101; b < 255; b++) begin
      rd_data = 16'(b); tick();
    end
    check("t3_drain_no_req", 32'(rd_req), 32'd0);
    rd_data = 16'd255; tick(); rd_valid = 1'b0;
    check("t3_flushed", 32'(pix_avail), 32'd0);
    check("t3_restart_req", 32'(rd_req), 32'd1);
    check("t3_restart_addr", 32'(rd_addr), 32'h0);
    rd_valid = 1'b1;
    repeat (3) tick();
    rd_valid = 1'b0;
    check("t3_req_ignores_beats", 32'(pix_avail), 32'd0);

    // ---- Pop while empty ----
    pix_pop = 1'b1; tick(); pix_pop = 1'b0;
    check("t4_underflow_set", 32'(underflow), 32'd1);
    check("t4_pix_data_zero", 32'(pix_data), 32'd0);
    check("t4_still_empty", 32'(pix_avail), 32'd0);
    tick();
    check("t4_underflow_sticky", 32'(underflow), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("t4_underflow_clear", 32'(underflow), 32'd0);

    // ---- Simultaneous write and pop at occupancy 10 ----
    start_burst("t5", 22'h0);
    for (int b = 0; b < 10; b++) begin
      rd_valid = 1'b1; rd_data = 16'(16'hA000 + b); tick();
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (pix_data !== 16'(16'hA000 + i)) bad++;
      rd_valid = 1'b1; rd_data = 16'(16'hA00A + i); pix_pop = 1'b1;
      tick();
    end
    rd_valid = 1'b0; pix_pop = 1'b0;
    n = 0;
    while (pix_avail && n < 50) begin
      if (pix_data !== 16'(16'hA005 + n)) bad++;
      pix_pop = 1'b1;
      tick();
      n++;
    end
    pix_pop = 1'b0;
    check("t5_occupancy", 32'(n), 32'd10);
    check("t5_order", 32'(bad), 32'd0);
    check("t5_no_underflow", 32'(underflow), 32'd0);

    // ---- Reset in the middle of a line-1 burst ----
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix_pop = 1'b1; tick(); pix_pop = 1'b0;
    check("t6_underflow_set", 32'(underflow), 32'd1);
    exp_x = 0; pop_cnt = 0; pop_bad = 0; auto_pop = 1'b1;
    for (int c = 0; c < CHUNKS; c++) do_burst("t6", 22'(c * BL), c * BL);
    start_burst("t6_line1", 22'(STRIDE));
    for (int b = 0; b < 50; b++) begin
      rd_valid = 1'b1; rd_data = 16'(b); tick();
    end
    check("t6_pre_line", 32'(line_count), 32'd1);
    check("t6_pre_avail", 32'(pix_avail), 32'd1);
    check("t6_pop_data", 32'(pop_bad), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t6_rd_req",    32'(rd_req),        32'd0);
    check("t6_rd_addr",   32'(rd_addr),       32'd0);
    check("t6_pix_data",  32'(pix_data),      32'd0);
    check("t6_avail",     32'(pix_avail),     32'd0);
    check("t6_underflow", 32'(underflow),     32'd0);
    check("t6_fetched",   32'(frame_fetched), 32'd0);
    check("t6_line",      32'(line_count),    32'd0);
    auto_pop = 1'b0; pix_pop = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      rd_valid = 1'b1; rd_data = 16'(i); rd_ack = i[0];
      tick();
      if (rd_req || pix_avail) seen++;
    end
    rd_valid = 1'b0; rd_ack = 1'b0;
    check("t6_quiet_after_reset", 32'(seen), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("t6_req_after_start", 32'(rd_req), 32'd1);
    check("t6_addr_after_start", 32'(rd_addr), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
